// File: rtl/mem_principal_ctrl.sv
// Backing main-memory controller behind the 2-way cache.
// Serves misses with optional dirty-victim write-back, then a fixed-latency refill.
module mem_principal_ctrl #(
    parameter int LAT = 3,
    parameter int DW  = 8,
    parameter int AW  = 5
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          req,
    input  logic [AW-1:0] rd_addr,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rd_data,
    output logic [2:0]    state_dbg
);

    localparam int DEPTH = 1 << AW;
    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WB_WAIT = 2'd1,
        RD_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] ra_q;
    logic [AW-1:0] wa_q;
    logic [DW-1:0] wd_q;
    logic          wb_q;

    // Words never written read back as their own address (power-up
    // content mem[i]=i); the written map survives reset like the array.
    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] written = '0;

    logic          commit;
    logic [DW-1:0] rd_val;

    assign commit = (state == WB_WAIT) && (cnt == 4'd0) && wb_q;

    // Read mux: written words come from the array, others from the address
    always_comb begin
        rd_val = DW'(ra_q);
        if (written[ra_q])
            rd_val = mem[ra_q];
    end

    // Array write port; not reset so stored data survives resetn
    always_ff @(posedge clock) begin
        if (commit) begin
            mem[wa_q]     <= wd_q;
            written[wa_q] <= 1'b1;
        end
    end

    // Main FSM: accept, optional write-back phase, read phase, done pulse
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ra_q    <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
            wb_q    <= 1'b0;
            rd_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        ra_q  <= rd_addr;
                        wa_q  <= wb_addr;
                        wd_q  <= wb_data;
                        wb_q  <= wb_en;
                        cnt   <= CNT_LOAD;
                        state <= wb_en ? WB_WAIT : RD_WAIT;
                    end
                end
                WB_WAIT: begin
                    if (cnt == 4'd0) begin
                        cnt   <= CNT_LOAD;
                        state <= RD_WAIT;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RD_WAIT: begin
                    if (cnt == 4'd0) begin
                        rd_data <= rd_val;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = {1'b0, state};

endmodule

// File: tb/tb_mem_principal_ctrl.sv
// Directed bench for mem_principal_ctrl: LAT=3 vector table plus
// hand sequences for reset abort and LAT=1 back-to-back service.
module tb_mem_principal_ctrl;

    logic       clock;
    logic       resetn;
    logic       req;
    logic [4:0] rd_addr;
    logic       wb_en;
    logic [4:0] wb_addr;
    logic [7:0] wb_data;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic [2:0] state_dbg;

    logic       req1;
    logic [4:0] rd_addr1;
    logic       busy1;
    logic       done1;
    logic [7:0] rd_data1;
    logic [2:0] state_dbg1;

    int total = 0;
    int bad   = 0;

    mem_principal_ctrl #(.LAT(3), .DW(8), .AW(5)) u_dut (
        .clock     (clock),
        .resetn    (resetn),
        .req       (req),
        .rd_addr   (rd_addr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .busy      (busy),
        .done      (done),
        .rd_data   (rd_data),
        .state_dbg (state_dbg)
    );

    mem_principal_ctrl #(.LAT(1), .DW(8), .AW(5)) u_dut1 (
        .clock     (clock),
        .resetn    (resetn),
        .req       (req1),
        .rd_addr   (rd_addr1),
        .wb_en     (1'b0),
        .wb_addr   (5'd0),
        .wb_data   (8'd0),
        .busy      (busy1),
        .done      (done1),
        .rd_data   (rd_data1),
        .state_dbg (state_dbg1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       req;
        logic [4:0] ra;
        logic       we;
        logic [4:0] wa;
        logic [7:0] wd;
        logic       eb;
        logic       ed;
        logic [7:0] er;
        logic [2:0] es;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic r, input logic [4:0] ra, input logic we,
                       input logic [4:0] wa, input logic [7:0] wd,
                       input logic eb, input logic ed, input logic [7:0] er,
                       input logic [2:0] es);
        vec_t v;
        v.req = r; v.ra = ra; v.we = we; v.wa = wa; v.wd = wd;
        v.eb = eb; v.ed = ed; v.er = er; v.es = es;
        vecs.push_back(v);
    endtask

    initial begin
        resetn = 1'b0; req = 1'b0; rd_addr = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        req1 = 1'b0; rd_addr1 = '0;

        // read-only, addr 5: done 4 cycles after accept
        add(1,  5, 0, 0, 8'h00, 1, 0, 8'h00, 2);
        add(0,  0, 0, 0, 8'h00, 1, 0, 8'h00, 2);
        add(0,  0, 0, 0, 8'h00, 1, 0, 8'h00, 2);
        add(0,  0, 0, 0, 8'h00, 1, 1, 8'h05, 3);
        add(0,  0, 0, 0, 8'h00, 0, 0, 8'h05, 0);
        // write-back A7 to 2, refill 9: done 7 cycles after accept
        add(1,  9, 1, 2, 8'hA7, 1, 0, 8'h05, 1);
        add(0,  0, 0, 0, 8'h00, 1, 0, 8'h05, 1);
        add(0,  0, 0, 0, 8'h00, 1, 0, 8'h05, 1);
        add(0,  0, 0, 0, 8'h00, 1, 0, 8'h05, 2);
        add(0,  0, 0, 0, 8'h00, 1, 0, 8'h05, 2);
        add(0,  0, 0, 0, 8'h00, 1, 0, 8'h05, 2);
        add(0,  0, 0, 0, 8'h00, 1, 1, 8'h09, 3);
        add(0,  0, 0, 0, 8'h00, 0, 0, 8'h09, 0);
        // read back addr 2
        add(1,  2, 0, 0, 8'h00, 1, 0, 8'h09, 2);
        add(0,  0, 0, 0, 8'h00, 1, 0, 8'h09, 2);
        add(0,  0, 0, 0, 8'h00, 1, 0, 8'h09, 2);
        add(0,  0, 0, 0, 8'h00, 1, 1, 8'hA7, 3);
        add(0,  0, 0, 0, 8'h00, 0, 0, 8'hA7, 0);
        // same-address hazard at 12
        add(1, 12, 1, 12, 8'h3C, 1, 0, 8'hA7, 1);
        add(0,  0, 0, 0, 8'h00, 1, 0, 8'hA7, 1);
        add(0,  0, 0, 0, 8'h00, 1, 0, 8'hA7, 1);
        add(0,  0, 0, 0, 8'h00, 1, 0, 8'hA7, 2);
        add(0,  0, 0, 0, 8'h00, 1, 0, 8'hA7, 2);
        add(0,  0, 0, 0, 8'h00, 1, 0, 8'hA7, 2);
        add(0,  0, 0, 0, 8'h00, 1, 1, 8'h3C, 3);
        add(0,  0, 0, 0, 8'h00, 0, 0, 8'h3C, 0);
        // req while busy and input toggling are ignored
        add(1,  7, 0, 0, 8'h00, 1, 0, 8'h3C, 2);
        add(1, 20, 1, 7, 8'h55, 1, 0, 8'h3C, 2);
        add(0, 20, 1, 7, 8'h55, 1, 0, 8'h3C, 2);
        add(0, 20, 0, 0, 8'h00, 1, 1, 8'h07, 3);
        add(0,  0, 0, 0, 8'h00, 0, 0, 8'h07, 0);
        add(0,  0, 0, 0, 8'h00, 0, 0, 8'h07, 0);
        add(0,  0, 0, 0, 8'h00, 0, 0, 8'h07, 0);

        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_dbg", 32'(state_dbg), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clock);
            req = vecs[i].req; rd_addr = vecs[i].ra; wb_en = vecs[i].we;
            wb_addr = vecs[i].wa; wb_data = vecs[i].wd;
            step();
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].eb));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].ed));
            chk($sformatf("v%0d_data", i), 32'(rd_data), 32'(vecs[i].er));
            chk($sformatf("v%0d_dbg", i), 32'(state_dbg), 32'(vecs[i].es));
        end

        // reset during write-back before its commit edge
        @(negedge clock);
        req = 1'b1; rd_addr = 5'd10; wb_en = 1'b1;
        wb_addr = 5'd3; wb_data = 8'hFF;
        step();
        chk("abort_wb", 32'(state_dbg), 32'd1);
        req = 1'b0; wb_en = 1'b0;
        step();
        chk("abort_wb2", 32'(state_dbg), 32'd1);
        resetn = 1'b0;
        #1;
        chk("abort_dbg", 32'(state_dbg), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_data", 32'(rd_data), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("abort_nodone", 32'(done), 32'd0);
        end
        @(negedge clock);
        resetn = 1'b1;
        req = 1'b1; rd_addr = 5'd3;
        step();
        req = 1'b0;
        step(); step(); step();
        chk("rd3_done", 32'(done), 32'd1);
        chk("rd3_data", 32'(rd_data), 32'h03);

        // LAT=1 back-to-back with req held high
        @(negedge clock);
        req1 = 1'b1; rd_addr1 = 5'd1;
        step();
        chk("l1_c1_dbg", 32'(state_dbg1), 32'd2);
        chk("l1_c1_done", 32'(done1), 32'd0);
        step();
        chk("l1_c2_done", 32'(done1), 32'd1);
        chk("l1_c2_data", 32'(rd_data1), 32'h01);
        rd_addr1 = 5'd31;
        step();
        chk("l1_c3_busy", 32'(busy1), 32'd0);
        chk("l1_c3_dbg", 32'(state_dbg1), 32'd0);
        step();
        chk("l1_c4_dbg", 32'(state_dbg1), 32'd2);
        chk("l1_c4_done", 32'(done1), 32'd0);
        step();
        chk("l1_c5_done", 32'(done1), 32'd1);
        chk("l1_c5_data", 32'(rd_data1), 32'h1F);
        req1 = 1'b0;
        step();
        chk("l1_c6_busy", 32'(busy1), 32'd0);
        chk("l1_c6_data", 32'(rd_data1), 32'h1F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_principal_ctrl.md
Name: mem_principal_ctrl

Overview:
- Backing main-memory controller directly downstream of the 2-way cache.
- Serves cache misses with a fixed-latency refill read. When the victim line is dirty, it first performs a write-back of the victim, then the refill.
- Holds a 32 x 8-bit memory array matching the cache's 5-bit address space.
- Exposes a busy/done handshake so the cache can stall until refill data is valid.

Parameters:
- LAT, 3, cycles spent in each memory phase (write-back or read); legal range 1..15.
- DW, 8, data width in bits.
- AW, 5, address width in bits; memory depth is 2**AW.

Ports:
- clock  input  1  single system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- req  input  1  miss request from cache; sampled only in IDLE.
- rd_addr  input  AW  refill address.
- wb_en  input  1  request includes a dirty-victim write-back.
- wb_addr  input  AW  victim address.
- wb_data  input  DW  victim data.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; rd_data is valid in this cycle.
- rd_data  output  DW  refill data; holds its value until the next read completes.
- state_dbg  output  3  current FSM state encoding, for LED/HEX debug.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, counter=0, busy=0, done=0, rd_data=0, latched request registers cleared, state_dbg=0.
  - The memory array is not cleared. Its power-up/simulation initial content is mem[i]=i.
- States and encodings: IDLE=0, WB_WAIT=1, RD_WAIT=2, DONE=3.
- IDLE:
  - If req=1 at a rising edge, latch rd_addr, wb_en, wb_addr and wb_data, and load counter=LAT-1.
  - Next state is WB_WAIT if wb_en=1, else RD_WAIT.
  - req=0 keeps the FSM in IDLE.
- WB_WAIT:
  - Decrement the counter each cycle.
  - At the edge where counter==0: write mem[wb_addr_latched]<=wb_data_latched, reload counter=LAT-1, go to RD_WAIT.
- RD_WAIT:
  - Decrement the counter each cycle.
  - At the edge where counter==0: rd_data<=mem[rd_addr_latched], go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge returns to IDLE unconditionally.
- Latency, counted from the accept edge:
  - Read-only request: done is high in cycle LAT+1.
  - Request with write-back: done is high in cycle 2*LAT+1.
  - The earliest next accept is the edge that ends the DONE cycle + 1, i.e. the first IDLE cycle.
- Outputs:
  - busy is combinational from state: 1 in WB_WAIT, RD_WAIT and DONE.
  - done is combinational: state==DONE.
- Boundary conditions:
  - req while busy is ignored. It is neither queued nor acknowledged, and the cache must hold req until it sees done.
  - req held high through DONE is not re-accepted in DONE. It is accepted at the first IDLE edge, giving back-to-back service with one IDLE cycle between requests.
  - Input changes after the accept edge have no effect; only latched values are used.
  - If wb_addr==rd_addr, the read returns the newly written wb_data, because the write commits before the read phase.
  - With LAT=1, each phase lasts exactly one cycle.
  - The counter is 4 bits, with no wrap-around for LAT<=15.
  - Reset asserted mid-operation aborts immediately to IDLE; done never pulses.
    - A write-back is committed only if its commit edge occurred before reset.
    - rd_data goes to 0.

Test Plan:
- Reset then read-only: LAT=3, req=1, rd_addr=5, wb_en=0 for one cycle -> busy rises after the accept edge; done=1 in cycle 4 with rd_data=8'h05; busy=0 in cycle 5.
- Write-back + refill: req=1, wb_en=1, wb_addr=2, wb_data=8'hA7, rd_addr=9 -> done in cycle 7 with rd_data=8'h09. A later read of addr 2 returns 8'hA7.
- Same-address hazard: wb_addr=rd_addr=12, wb_data=8'h3C -> done returns rd_data=8'h3C.
- Request while busy: second req with rd_addr=20 pulsed during RD_WAIT -> ignored; only one done pulse, with data from the first request. Inputs toggled after accept do not alter the result.
- Reset mid write-back: assert resetn=0 during WB_WAIT before commit, with wb_addr=3, wb_data=8'hFF -> state=IDLE, busy=0, rd_data=0, no done pulse. A subsequent read of addr 3 returns 8'h03.
- Back-to-back and LAT=1: req held high with rd_addr=1 then 31 -> done pulses in cycles 2 and 5 with rd_data 8'h01 then 8'h1F; exactly one IDLE cycle between the two requests.
